triangle_assembler: RTL

//  Upstream feeder for the rasterizer top. Accepts a vertex stream, one vertex_t per handshake.

---
 rtl/triangle_assembler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/triangle_assembler.sv
// Vertex-stream to triangle assembler (list/strip/fan) with a small triangle FIFO.
// Optional degenerate-triangle culling: define TRI_ASM_CULL_EN.
package tri_asm_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t a;
    vertex_t b;
    vertex_t c;
  } tri_t;

  typedef enum logic [1:0] {
    M_LIST  = 2'd0,
    M_STRIP = 2'd1,
    M_FAN   = 2'd2,
    M_RSV   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_CNT0 = 2'd0,
    S_CNT1 = 2'd1,
    S_CNT2 = 2'd2
  } asm_st_e;

endpackage

module triangle_assembler
  import tri_asm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  vertex_t          vtx_in,
  input  logic             vtx_valid,
  output logic             vtx_ready,
  input  logic [1:0]       prim_mode,
  input  logic             prim_restart,
  output vertex_t          v0,
  output vertex_t          v1,
  output vertex_t          v2,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [CW-1:0]    fifo_count,
  output logic [CNT_W-1:0] tri_count,
`ifdef TRI_ASM_CULL_EN
  output logic [CNT_W-1:0] cull_count,
`endif
  output logic             busy
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  asm_st_e st_q, st_d;
  vertex_t a_q, a_d;
  vertex_t b_q, b_d;
  logic    par_q, par_d;
  mode_e   mode_q, mode_d;
  mode_e   mode_eff;

  tri_t    push_tri;
  logic    done;
  logic    push;
  logic    pop;
  logic    vtx_acc;

  tri_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  tri_t          head;

  assign vtx_ready = rst_n && (fifo_count != DEPTH_C);
  assign vtx_acc   = vtx_valid && vtx_ready;
  assign tri_valid = (fifo_count != '0);
  assign pop       = tri_valid && tri_ready;
  assign busy      = (st_q != S_CNT0) || tri_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= S_CNT0;
      a_q    <= '0;
      b_q    <= '0;
      par_q  <= 1'b0;
      mode_q <= M_LIST;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      par_q  <= par_d;
      mode_q <= mode_d;
    end
  end

  // A vertex arriving at cnt0 or with a restart uses the live mode input.
  always_comb begin
    st_d     = st_q;
    a_d      = a_q;
    b_d      = b_q;
    par_d    = par_q;
    mode_d   = mode_q;
    mode_eff = mode_q;
    push_tri = '0;
    done     = 1'b0;
    if ((st_q == S_CNT0) || prim_restart) begin
      mode_d   = mode_e'(prim_mode);
      mode_eff = mode_e'(prim_mode);
    end
    if (prim_restart) begin
      st_d  = S_CNT0;
      par_d = 1'b0;
    end
    if (vtx_acc) begin
      if (prim_restart) begin
        a_d  = vtx_in;
        st_d = S_CNT1;
      end else begin
        unique case (st_q)
          S_CNT0: begin
            a_d   = vtx_in;
            par_d = 1'b0;
            st_d  = S_CNT1;
          end
          S_CNT1: begin
            b_d  = vtx_in;
            st_d = S_CNT2;
          end
          S_CNT2: begin
            done = 1'b1;
            unique case (1'b1)
              mode_eff == M_STRIP: begin
                push_tri = par_q ? {b_q, a_q, vtx_in}
                                 : {a_q, b_q, vtx_in};
                a_d   = b_q;
                b_d   = vtx_in;
                par_d = ~par_q;
              end
              mode_eff == M_FAN: begin
                push_tri = {a_q, b_q, vtx_in};
                b_d      = vtx_in;
              end
              default: begin
                push_tri = {a_q, b_q, vtx_in};
                st_d     = S_CNT0;
              end
            endcase
          end
          default: st_d = S_CNT0;
        endcase
      end
    end
  end

`ifdef TRI_ASM_CULL_EN
  logic degen;
  logic cull;

  always_comb begin
    degen = ((push_tri.a.x == push_tri.b.x) && (push_tri.a.y == push_tri.b.y))
         || ((push_tri.a.x == push_tri.c.x) && (push_tri.a.y == push_tri.c.y))
         || ((push_tri.b.x == push_tri.c.x) && (push_tri.b.y == push_tri.c.y));
  end

  assign push = done && !degen;
  assign cull = done && degen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cull_count <= '0;
    end else if (cull) begin
      cull_count <= cull_count + CNT_W'(1);
    end
  end
`else
  assign push = done;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_tri;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tri_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        tri_count <= tri_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Empty FIFO presents zeros so the outputs match the reset state.
  assign head = mem[rd_ptr];
  assign v0   = tri_valid ? head.a : '0;
  assign v1   = tri_valid ? head.b : '0;
  assign v2   = tri_valid ? head.c : '0;

endmodule
